// File: rtl/mgia_fetch_if.sv
// Bus bundle for the MGIA video fetch stage: Wishbone-style read master
// towards video RAM plus the MGIA_DAT/MGIA_ACK word handshake.
interface mgia_fetch_if #(
  parameter int unsigned ADDR_W = 23
);
  logic [ADDR_W-1:0] MEM_ADR_O;
  logic              MEM_CYC_O;
  logic              MEM_STB_O;
  logic [15:0]       MEM_DAT_I;
  logic              MEM_ACK_I;
  logic              MGIA_STB_I;
  logic [15:0]       MGIA_DAT_O;
  logic              MGIA_ACK_O;

  // Fetch stage side
  modport master (
    output MEM_ADR_O, MEM_CYC_O, MEM_STB_O,
    input  MEM_DAT_I, MEM_ACK_I,
    input  MGIA_STB_I,
    output MGIA_DAT_O, MGIA_ACK_O
  );

  // Memory / MGIA side
  modport slave (
    input  MEM_ADR_O, MEM_CYC_O, MEM_STB_O,
    output MEM_DAT_I, MEM_ACK_I,
    output MGIA_STB_I,
    input  MGIA_DAT_O, MGIA_ACK_O
  );
endinterface

// File: rtl/mgia_fetch.sv
// Video fetch stage: reads framebuffer words from video RAM into a prefetch
// FIFO and hands them to the MGIA shifter; restarts at BASE_ADDR each frame.
module mgia_fetch #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 19200
) (
  input  logic          CLK_I_50MHZ,
  input  logic          RST_I_N,
  input  logic          FRAME_I,
  mgia_fetch_if.master  bus,
  output logic          UNDERRUN_O
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WC_W  = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DONE  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              stb_q, stb_d;
  logic [WC_W-1:0]   wc_q, wc_d;

  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0]  cnt_q, fill_d;
  logic              under_q;

  logic empty, full, pop, push, push_ok, flush, mem_ack;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign mem_ack = stb_q & bus.MEM_ACK_I;
  assign pop     = bus.MGIA_STB_I & ~empty & ~FRAME_I;

  assign bus.MEM_ADR_O  = adr_q;
  assign bus.MEM_CYC_O  = stb_q;
  assign bus.MEM_STB_O  = stb_q;
  assign bus.MGIA_ACK_O = pop;
  assign bus.MGIA_DAT_O = empty ? '0 : fifo_mem[rp_q];
  assign UNDERRUN_O     = under_q;

  // Next-state, bus strobe, address/word counter and FIFO push/flush decisions
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    stb_d   = stb_q;
    wc_d    = wc_q;
    push    = 1'b0;
    flush   = 1'b0;
    push_ok = 1'b0;
    fill_d  = cnt_q;
    case (state_q)
      FETCH: begin
        if (FRAME_I) begin
          flush = 1'b1;
          if (stb_q && !bus.MEM_ACK_I) begin
            // Read in flight: address must stay put until the slave answers.
            state_d = DRAIN;
            stb_d   = 1'b1;
          end else begin
            adr_d = ADDR_W'(BASE_ADDR);
            wc_d  = '0;
            stb_d = 1'b1;
          end
        end else begin
          if (mem_ack) begin
            push  = 1'b1;
            adr_d = adr_q + ADDR_W'(1);
            wc_d  = wc_q + WC_W'(1);
          end
          push_ok = push & (~full | pop);
          fill_d  = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
          if (wc_d == WC_W'(FRAME_WORDS)) begin
            state_d = DONE;
            stb_d   = 1'b0;
          end else begin
            stb_d = (fill_d < CNT_W'(FIFO_DEPTH));
          end
        end
      end
      DONE: begin
        stb_d = 1'b0;
        if (FRAME_I) begin
          flush   = 1'b1;
          adr_d   = ADDR_W'(BASE_ADDR);
          wc_d    = '0;
          state_d = FETCH;
          stb_d   = 1'b1;
        end
      end
      DRAIN: begin
        stb_d = 1'b1;
        if (bus.MEM_ACK_I) begin
          flush   = 1'b1;
          adr_d   = ADDR_W'(BASE_ADDR);
          wc_d    = '0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
        stb_d   = 1'b0;
      end
    endcase
    if (state_q != FETCH) begin
      fill_d = cnt_q - CNT_W'(pop);
    end
  end

  // FSM, bus master and FIFO pointer registers
  always_ff @(posedge CLK_I_50MHZ or negedge RST_I_N) begin
    if (!RST_I_N) begin
      state_q <= FETCH;
      adr_q   <= ADDR_W'(BASE_ADDR);
      stb_q   <= 1'b0;
      wc_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      stb_q   <= stb_d;
      wc_q    <= wc_d;
      if (flush) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push_ok) wp_q <= wp_q + PTR_W'(1);
        if (pop)     rp_q <= rp_q + PTR_W'(1);
        cnt_q <= fill_d;
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge CLK_I_50MHZ) begin
    if (push_ok && !flush) begin
      fifo_mem[wp_q] <= bus.MEM_DAT_I;
    end
  end

  // Sticky underrun flag; a frame pulse clears it even if MGIA asks that cycle
  always_ff @(posedge CLK_I_50MHZ or negedge RST_I_N) begin
    if (!RST_I_N) begin
      under_q <= 1'b0;
    end else if (FRAME_I) begin
      under_q <= 1'b0;
    end else if (bus.MGIA_STB_I && empty) begin
      under_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mgia_fetch.sv
// Scoreboard bench for mgia_fetch: a memory model answers reads, a monitor
// compares the MGIA word stream, bus behaviour and the underrun flag.
module tb_mgia_fetch;
  localparam int unsigned FW    = 48;
  localparam int unsigned DELAY = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame = 1'b0;
  logic under;
  logic [15:0] dat_xor = 16'h0000;
  int mode = 0;          // 0: ACK tied high, 1: ACK held low, 2: ACK after DELAY
  int wcnt = 0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] q[$];
  logic [22:0] exp_addr = '0;
  logic [22:0] last_adr = '0;
  logic [22:0] prev_adr = '0;
  logic        draining = 1'b0;
  logic        exp_under = 1'b0;
  logic        prev_pend = 1'b0;
  logic        xfer, was_empty, exp_ack;
  logic [15:0] exp_dat;
  int reads_total = 0;
  int reads_frame = 0;
  int cyc_hi = 0;

  mgia_fetch_if #(.ADDR_W(23)) bus ();

  mgia_fetch #(
    .FIFO_DEPTH(16),
    .ADDR_W(23),
    .BASE_ADDR(0),
    .FRAME_WORDS(FW)
  ) dut (
    .CLK_I_50MHZ(clk),
    .RST_I_N(rst_n),
    .FRAME_I(frame),
    .bus(bus),
    .UNDERRUN_O(under)
  );

  always #5 clk = ~clk;

  assign bus.MEM_DAT_I = bus.MEM_ADR_O[15:0] ^ dat_xor;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_frame(input logic stb_during);
    bus.MGIA_STB_I = stb_during;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    bus.MGIA_STB_I = 1'b0;
  endtask

  // Memory slave model
  always @(posedge clk) begin
    #1;
    case (mode)
      0: bus.MEM_ACK_I = 1'b1;
      1: bus.MEM_ACK_I = 1'b0;
      default: begin
        if (bus.MEM_STB_O) begin
          if (wcnt >= int'(DELAY)) begin
            bus.MEM_ACK_I = 1'b1;
            wcnt = 0;
          end else begin
            bus.MEM_ACK_I = 1'b0;
            wcnt++;
          end
        end else begin
          bus.MEM_ACK_I = 1'b0;
          wcnt = 0;
        end
      end
    endcase
  end

  // Monitor / scoreboard, mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_addr = '0;
      draining = 1'b0;
      exp_under = 1'b0;
      prev_pend = 1'b0;
      reads_frame = 0;
    end else begin
      xfer = bus.MEM_STB_O && bus.MEM_ACK_I;
      if (prev_pend) begin
        check("stb_hold", 32'(bus.MEM_STB_O), 32'd1);
        check("adr_hold", 32'(bus.MEM_ADR_O), 32'(prev_adr));
      end
      check("cyc", 32'(bus.MEM_CYC_O), 32'(bus.MEM_STB_O));
      was_empty = (q.size() == 0);
      exp_ack = bus.MGIA_STB_I && !was_empty && !frame;
      exp_dat = was_empty ? 16'h0000 : q[0];
      check("mgia_ack", 32'(bus.MGIA_ACK_O), 32'(exp_ack));
      check("mgia_dat", 32'(bus.MGIA_DAT_O), 32'(exp_dat));
      if (exp_ack) void'(q.pop_front());
      check("underrun", 32'(under), 32'(exp_under));
      if (frame) exp_under = 1'b0;
      else if (bus.MGIA_STB_I && was_empty) exp_under = 1'b1;
      if (xfer) begin
        reads_total++;
        check("mem_adr", 32'(bus.MEM_ADR_O), 32'(exp_addr));
        if (draining || frame) begin
          draining = 1'b0;
          exp_addr = '0;
        end else begin
          q.push_back(exp_addr[15:0] ^ dat_xor);
          last_adr = exp_addr;
          exp_addr = exp_addr + 23'd1;
          reads_frame++;
        end
      end
      if (frame) begin
        q.delete();
        reads_frame = 0;
        if (!xfer) begin
          if (bus.MEM_STB_O) draining = 1'b1;
          else exp_addr = '0;
        end
      end
      if (bus.MEM_CYC_O) cyc_hi++;
      prev_pend = bus.MEM_STB_O && !bus.MEM_ACK_I;
      prev_adr = bus.MEM_ADR_O;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int snap;
    bus.MGIA_STB_I = 1'b1;
    bus.MEM_ACK_I = 1'b1;
    tick(3);
    check("rst_cyc", 32'(bus.MEM_CYC_O), 32'd0);
    check("rst_stb", 32'(bus.MEM_STB_O), 32'd0);
    check("rst_adr", 32'(bus.MEM_ADR_O), 32'd0);
    check("rst_ack", 32'(bus.MGIA_ACK_O), 32'd0);
    check("rst_dat", 32'(bus.MGIA_DAT_O), 32'd0);
    check("rst_under", 32'(under), 32'd0);

    // Prefill with ACK tied high and MGIA idle
    bus.MGIA_STB_I = 1'b0;
    rst_n = 1'b1;
    tick(30);
    check("prefill_reads", 32'(reads_total), 32'd16);
    check("prefill_cyc", 32'(bus.MEM_CYC_O), 32'd0);
    check("prefill_under", 32'(under), 32'd0);

    // MGIA consuming every cycle
    bus.MGIA_STB_I = 1'b1;
    tick(40);
    bus.MGIA_STB_I = 1'b0;
    check("resume_fetch", 32'(reads_total > 16), 32'd1);
    check("stream_under", 32'(under), 32'd0);

    // Full frame with one word per 16 clocks
    pulse_frame(1'b0);
    tick(20);
    for (int i = 0; i < int'(FW) * 16; i++) begin
      bus.MGIA_STB_I = ((i % 16) == 0);
      tick();
    end
    bus.MGIA_STB_I = 1'b0;
    check("frame_reads", 32'(reads_frame), 32'(FW));
    check("frame_last_adr", 32'(last_adr), 32'(FW - 1));
    snap = cyc_hi;
    tick(40);
    check("done_idle", 32'(cyc_hi - snap), 32'd0);
    check("frame_under", 32'(under), 32'd0);

    // Frame pulse with a read held by a slow slave
    dat_xor = 16'h5A00;
    mode = 2;
    pulse_frame(1'b0);
    t = 0;
    while (!(q.size() >= 2 && bus.MEM_STB_O && !bus.MEM_ACK_I) && t < 300) begin
      tick();
      t++;
    end
    check("drain_setup_timeout", 32'(t < 300), 32'd1);
    pulse_frame(1'b0);
    t = 0;
    while (draining && t < 50) begin
      tick();
      t++;
    end
    check("drain_timeout", 32'(t < 50), 32'd1);
    check("drain_empty", 32'(bus.MGIA_DAT_O), 32'd0);
    tick(40);

    // Starved MGIA: no ACK from memory
    mode = 1;
    pulse_frame(1'b0);
    bus.MGIA_STB_I = 1'b1;
    tick(10);
    bus.MGIA_STB_I = 1'b0;
    tick(3);
    check("underrun_sticky", 32'(under), 32'd1);
    pulse_frame(1'b1);
    check("underrun_clear", 32'(under), 32'd0);

    // Reset mid-read with the FIFO half full
    mode = 2;
    t = 0;
    while (!(q.size() >= 8 && bus.MEM_STB_O && !bus.MEM_ACK_I) && t < 400) begin
      tick();
      t++;
    end
    check("half_full_timeout", 32'(t < 400), 32'd1);
    rst_n = 1'b0;
    bus.MGIA_STB_I = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(bus.MEM_CYC_O), 32'd0);
    check("mid_rst_stb", 32'(bus.MEM_STB_O), 32'd0);
    check("mid_rst_adr", 32'(bus.MEM_ADR_O), 32'd0);
    check("mid_rst_ack", 32'(bus.MGIA_ACK_O), 32'd0);
    check("mid_rst_dat", 32'(bus.MGIA_DAT_O), 32'd0);
    check("mid_rst_under", 32'(under), 32'd0);
    tick(2);
    bus.MGIA_STB_I = 1'b0;
    rst_n = 1'b1;
    snap = reads_total;
    t = 0;
    while (reads_total == snap && t < 50) begin
      tick();
      t++;
    end
    check("post_rst_read_timeout", 32'(t < 50), 32'd1);
    mode = 0;
    tick(5);
    bus.MGIA_STB_I = 1'b1;
    tick(30);
    bus.MGIA_STB_I = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
